// File: rtl/nastilite_pkg.sv
// Shared types for the NASTI-lite register slave: response codes,
// handshake FSM states and the byte-lane strobe merge helper.
package nastilite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETTLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_SW = MAX_DW / 8;

  // Lanes whose strobe bit is clear keep the old byte.
  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0] old_v,
    input logic [MAX_DW-1:0] new_v,
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(MAX_SW); i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nastilite_regfile.sv
// Register bank: NR x DW flops, one byte-strobed write port, one async read.
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i/wstrb_i (write), raddr_i/rdata_o (read).
module nastilite_regfile
  import nastilite_pkg::*;
#(
  parameter int DW = 64,
  parameter int NR = 16,
  parameter int IW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] regs_q [NR];
  logic [MAX_DW-1:0] merged;

  // Widen to the helper's fixed 64-bit shape; upper lanes unused at DW=32.
  assign merged = strb_merge(MAX_DW'(regs_q[waddr_i]),
                             MAX_DW'(wdata_i),
                             MAX_SW'(wstrb_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= DW'(merged);
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/nastilite_reg_slave.sv
// NASTI-lite slave exposing a bank of DW-wide CSRs (AW/W/B and AR/R channels).
// Ports: clk, rst, aw_*, w_*, b_*, ar_*, r_*; optional macro NASTILITE_SLVERR_EN.
module nastilite_reg_slave
  import nastilite_pkg::*;
#(
  parameter int C_NASTI_ADDR_WIDTH = 16,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1,
  parameter int C_NUM_REGS         = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr,
  input  logic [2:0]                      aw_prot,
  input  logic [3:0]                      aw_qos,
  input  logic [3:0]                      aw_region,
  input  logic [C_NASTI_USER_WIDTH-1:0]   aw_user,
  input  logic                            aw_valid,
  output logic                            aw_ready,
  input  logic [C_NASTI_DATA_WIDTH-1:0]   w_data,
  input  logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb,
  input  logic [C_NASTI_USER_WIDTH-1:0]   w_user,
  input  logic                            w_valid,
  output logic                            w_ready,
  output logic [1:0]                      b_resp,
  output logic [C_NASTI_USER_WIDTH-1:0]   b_user,
  output logic                            b_valid,
  input  logic                            b_ready,
  input  logic [C_NASTI_ADDR_WIDTH-1:0]   ar_addr,
  input  logic [2:0]                      ar_prot,
  input  logic [3:0]                      ar_qos,
  input  logic [3:0]                      ar_region,
  input  logic [C_NASTI_USER_WIDTH-1:0]   ar_user,
  input  logic                            ar_valid,
  output logic                            ar_ready,
  output logic [C_NASTI_DATA_WIDTH-1:0]   r_data,
  output logic [1:0]                      r_resp,
  output logic [C_NASTI_USER_WIDTH-1:0]   r_user,
  output logic                            r_valid,
  input  logic                            r_ready
);

  localparam int AW    = C_NASTI_ADDR_WIDTH;
  localparam int DW    = C_NASTI_DATA_WIDTH;
  localparam int UW    = C_NASTI_USER_WIDTH;
  localparam int SW    = DW / 8;
  localparam int SHIFT = $clog2(SW);
  localparam int IW    = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $fatal(1, "C_NASTI_DATA_WIDTH must be 32 or 64");
  end

`ifdef NASTILITE_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> SHIFT) < AW'(C_NUM_REGS);
  endfunction

  logic unused_ok;
  assign unused_ok = ^{aw_prot, aw_qos, aw_region,
                       ar_prot, ar_qos, ar_region, w_user};

  // Readies stay low until the first edge after reset release.
  logic alive_q;

  logic          aw_held_q, w_held_q;
  logic [AW-1:0] aw_addr_q;
  logic [UW-1:0] aw_user_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  wr_state_t     wr_q, wr_d;
  logic          reg_we;

  rd_state_t     rd_q, rd_d;
  logic [DW-1:0] r_data_q;
  logic [1:0]    r_resp_q;
  logic [UW-1:0] r_user_q;
  logic [DW-1:0] rf_rdata;

  logic aw_hs, w_hs, b_hs, ar_hs;

  assign b_valid  = (wr_q == WR_RESP);
  assign aw_ready = alive_q && !aw_held_q && !b_valid;
  assign w_ready  = alive_q && !w_held_q && !b_valid;
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;
  assign b_hs     = b_valid && b_ready;
  assign b_user   = aw_user_q;
  assign b_resp   = in_range(aw_addr_q) ? RESP_OKAY : OOR_RESP;

  assign r_valid  = (rd_q == RD_RESP);
  assign ar_ready = alive_q && (rd_q == RD_IDLE);
  assign ar_hs    = ar_valid && ar_ready;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_user   = r_user_q;

  // Commit once both halves are held; response follows a cycle later.
  always_comb begin
    wr_d   = wr_q;
    reg_we = 1'b0;
    unique case (wr_q)
      WR_IDLE: begin
        if (aw_held_q && w_held_q) begin
          reg_we = in_range(aw_addr_q);
          wr_d   = WR_SETTLE;
        end
      end
      WR_SETTLE: wr_d = WR_RESP;
      WR_RESP:   if (b_ready) wr_d = WR_IDLE;
      default:   wr_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      RD_IDLE: if (ar_hs) rd_d = RD_RESP;
      RD_RESP: if (r_ready) rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q   <= 1'b0;
      wr_q      <= WR_IDLE;
      rd_q      <= RD_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_user_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_user_q  <= '0;
    end else begin
      alive_q <= 1'b1;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= aw_addr;
        aw_user_q <= aw_user;
      end else if (b_hs) begin
        aw_held_q <= 1'b0;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end else if (b_hs) begin
        w_held_q <= 1'b0;
      end
      if (ar_hs) begin
        r_data_q <= in_range(ar_addr) ? rf_rdata : '0;
        r_resp_q <= in_range(ar_addr) ? RESP_OKAY : OOR_RESP;
        r_user_q <= ar_user;
      end
    end
  end

  nastilite_regfile #(
    .DW (DW),
    .NR (C_NUM_REGS),
    .IW (IW)
  ) u_regfile (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (reg_we),
    .waddr_i (IW'(aw_addr_q >> SHIFT)),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .raddr_i (IW'(ar_addr >> SHIFT)),
    .rdata_o (rf_rdata)
  );

endmodule

// File: tb/tb_nastilite_reg_slave.sv
// Scoreboard bench for nastilite_reg_slave: directed cases plus random
// read/write traffic against an array model of the register bank.
module tb_nastilite_reg_slave;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int UW = 1;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0] aw_addr = '0, ar_addr = '0;
  logic [2:0]    aw_prot = '0, ar_prot = '0;
  logic [3:0]    aw_qos = '0, ar_qos = '0;
  logic [3:0]    aw_region = '0, ar_region = '0;
  logic [UW-1:0] aw_user = '0, ar_user = '0, w_user = '0;
  logic          aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
  logic          b_ready = 1'b0, r_ready = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [SW-1:0] w_strb = '0;
  logic          aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [1:0]    b_resp, r_resp;
  logic [UW-1:0] b_user, r_user;
  logic [DW-1:0] r_data;

  always #5 clk = ~clk;

  nastilite_reg_slave #(
    .C_NASTI_ADDR_WIDTH (AW),
    .C_NASTI_DATA_WIDTH (DW),
    .C_NASTI_USER_WIDTH (UW),
    .C_NUM_REGS         (NR)
  ) dut (
    .clk (clk), .rst (rst),
    .aw_addr (aw_addr), .aw_prot (aw_prot), .aw_qos (aw_qos),
    .aw_region (aw_region), .aw_user (aw_user),
    .aw_valid (aw_valid), .aw_ready (aw_ready),
    .w_data (w_data), .w_strb (w_strb), .w_user (w_user),
    .w_valid (w_valid), .w_ready (w_ready),
    .b_resp (b_resp), .b_user (b_user),
    .b_valid (b_valid), .b_ready (b_ready),
    .ar_addr (ar_addr), .ar_prot (ar_prot), .ar_qos (ar_qos),
    .ar_region (ar_region), .ar_user (ar_user),
    .ar_valid (ar_valid), .ar_ready (ar_ready),
    .r_data (r_data), .r_resp (r_resp), .r_user (r_user),
    .r_valid (r_valid), .r_ready (r_ready)
  );

  typedef struct {
    logic [1:0] resp;
    logic       user;
  } b_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        user;
  } r_exp_t;

  int checks = 0;
  int passed = 0;
  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [63:0] model [NR];
  logic hold_rdy = 1'b0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [1:0] oor_resp();
`ifdef NASTILITE_SLVERR_EN
    return 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  // Response-side readies: random, or forced low for backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_rdy) begin
        b_ready = 1'b0;
        r_ready = 1'b0;
      end else begin
        b_ready = ($urandom_range(0, 3) != 0);
        r_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks that a
  // pending response stays put and blocks new requests.
  initial begin
    logic        pbv, prv;
    logic [1:0]  pb_resp, pr_resp;
    logic        pb_user, pr_user;
    logic [63:0] pr_data;
    b_exp_t be;
    r_exp_t re;
    pbv = 1'b0;
    prv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pbv = 1'b0;
        prv = 1'b0;
        continue;
      end
      if (pbv)
        chk(b_valid === 1'b1 && b_resp === pb_resp && b_user === pb_user,
            "b_stable", {61'd0, b_valid, b_resp}, {61'd1, pb_resp});
      if (prv)
        chk(r_valid === 1'b1 && r_data === pr_data && r_resp === pr_resp,
            "r_stable", r_data, pr_data);
      if (b_valid)
        chk(!aw_ready && !w_ready, "aw_w_blocked",
            {62'd0, aw_ready, w_ready}, 64'd0);
      if (r_valid)
        chk(!ar_ready, "ar_blocked", {63'd0, ar_ready}, 64'd0);
      if (b_valid && b_ready) begin
        if (bq.size() == 0) begin
          chk(1'b0, "b_unexpected", {62'd0, b_resp}, 64'd0);
        end else begin
          be = bq.pop_front();
          chk(b_resp === be.resp, "b_resp", {62'd0, b_resp}, {62'd0, be.resp});
          chk(b_user === be.user, "b_user", {63'd0, b_user}, {63'd0, be.user});
        end
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) begin
          chk(1'b0, "r_unexpected", r_data, 64'd0);
        end else begin
          re = rq.pop_front();
          chk(r_data === re.data, "r_data", r_data, re.data);
          chk(r_resp === re.resp, "r_resp", {62'd0, r_resp}, {62'd0, re.resp});
          chk(r_user === re.user, "r_user", {63'd0, r_user}, {63'd0, re.user});
        end
      end
      pbv = b_valid && !b_ready;
      pb_resp = b_resp;
      pb_user = b_user;
      prv = r_valid && !r_ready;
      pr_data = r_data;
      pr_resp = r_resp;
      pr_user = r_user;
    end
  end

  task automatic send_aw(input logic [15:0] a, input logic u);
    int n;
    aw_addr = a;
    aw_user = u;
    aw_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!aw_ready && n < 200);
    if (!aw_ready) chk(1'b0, "aw_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n;
    w_data = d;
    w_strb = s;
    w_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_ready && n < 200);
    if (!w_ready) chk(1'b0, "w_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a, input logic u);
    int n;
    ar_addr = a;
    ar_user = u;
    ar_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ar_ready && n < 200);
    if (!ar_ready) chk(1'b0, "ar_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 ar_valid = 1'b0;
  endtask

  // lat = clock edges from the later of the AW/W handshakes to b_valid.
  task automatic do_write(input logic [15:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic u,
                          input int aw_dly, input int w_dly,
                          output int lat);
    int idx;
    int n;
    b_exp_t e;
    idx = int'(a >> 3);
    e.resp = (idx < NR) ? 2'b00 : oor_resp();
    e.user = u;
    bq.push_back(e);
    fork
      begin
        if (aw_dly > 0) begin
          repeat (aw_dly) @(posedge clk);
          #1;
        end
        send_aw(a, u);
      end
      begin
        if (w_dly > 0) begin
          repeat (w_dly) @(posedge clk);
          #1;
        end
        send_w(d, s);
      end
    join
    @(negedge clk);
    lat = 0;
    while (!b_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n = 0;
    while (!(b_valid && b_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(b_valid && b_ready)) chk(1'b0, "b_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (idx < NR)
      for (int i = 0; i < 8; i++)
        if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic do_read(input logic [15:0] a, input logic u,
                         output logic [63:0] got);
    int idx;
    int n;
    r_exp_t e;
    idx = int'(a >> 3);
    e.data = (idx < NR) ? model[idx] : 64'd0;
    e.resp = (idx < NR) ? 2'b00 : oor_resp();
    e.user = u;
    rq.push_back(e);
    send_ar(a, u);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(r_valid && r_ready) && n < 200);
    if (!(r_valid && r_ready)) chk(1'b0, "r_timeout", 64'd0, 64'd1);
    got = r_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    logic [63:0] got, got2;
    for (int i = 0; i < NR; i++) model[i] = 64'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({aw_ready, w_ready, ar_ready, b_valid, r_valid} === 5'd0,
        "rst_hs", {59'd0, aw_ready, w_ready, ar_ready, b_valid, r_valid}, 64'd0);
    chk({b_resp, r_resp, b_user, r_user} === 6'd0, "rst_resp",
        {58'd0, b_resp, r_resp, b_user, r_user}, 64'd0);
    chk(r_data === 64'd0, "rst_rdata", r_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk({aw_ready, w_ready, ar_ready} === 3'b000, "rdy_pre",
        {61'd0, aw_ready, w_ready, ar_ready}, 64'd0);
    @(negedge clk);
    chk({aw_ready, w_ready, ar_ready} === 3'b111, "rdy_post",
        {61'd0, aw_ready, w_ready, ar_ready}, 64'd7);
    @(posedge clk);
    #1;

    do_write(16'h0008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 0, 0, lat);
    chk(lat == 2, "wr_latency", 64'(lat), 64'd2);
    do_read(16'h0008, 1'b0, got);
    chk(got === 64'hDEADBEEF_CAFEF00D, "t2_data", got, 64'hDEADBEEF_CAFEF00D);

    do_write(16'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1, 3, 0, lat);
    do_read(16'h0010, 1'b1, got);
    chk(got === 64'h00000000_FFFFFFFF, "t3_data", got, 64'h00000000_FFFFFFFF);

    hold_rdy = 1'b1;
    fork
      do_write(16'h0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 0, 0, lat);
      do_read(16'h0008, 1'b1, got);
      begin
        repeat (10) @(posedge clk);
        #1 hold_rdy = 1'b0;
      end
    join

    do_read(16'h0100, 1'b0, got);
    chk(got === 64'd0, "t5_data", got, 64'd0);

    fork
      do_read(16'h0018, 1'b0, got);
      do_write(16'h001B, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b0, 0, 0, lat);
    join
    chk(got === 64'h0123_4567_89AB_CDEF, "t6_old", got, 64'h0123_4567_89AB_CDEF);
    do_read(16'h0018, 1'b0, got2);
    chk(got2 === 64'hA5A5_5A5A_0F0F_F0F0, "t6_new", got2, 64'hA5A5_5A5A_0F0F_F0F0);

    for (int k = 0; k < 80; k++) begin
      logic [15:0] a;
      a = 16'(($urandom_range(0, 19) << 3) | $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        do_write(a, {$urandom, $urandom}, 8'($urandom), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), lat2);
      else
        do_read(a, 1'($urandom), got);
    end

    repeat (5) @(posedge clk);
    chk(bq.size() == 0, "b_drained", 64'(bq.size()), 64'd0);
    chk(rq.size() == 0, "r_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
